// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC measurement controller: FSM state codes
// and the default geometry of the coarse/fine result word.
package tdc_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // Default geometry
    localparam int DEF_COARSE_W    = 16;
    localparam int DEF_FINE_W      = 4;
    localparam int DEF_TIMEOUT     = 1000;
    localparam int DEF_SYNC_STAGES = 2;

    // Result word reported when the window closes without a hit
    localparam logic [DEF_COARSE_W+DEF_FINE_W-1:0] DEF_TIMEOUT_CODE = '1;

endpackage

// File: rtl/tdc_sync_edge.sv
// Synchroniser for the delay line's COUNT_ON plus a rising-edge detector.
// The edge output is combinational from the last sync stage so that a level
// first sampled at counter value N is reported while the counter reads
// N + STAGES. Pulsing 'arm' primes the detector as if the line were already
// high, so a level that is present when a measurement starts is not a hit.
module tdc_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic arm,
    output logic rise
);

    wire [STAGES-1:0] chain;
    logic             prev_reg;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic d;
            logic q_reg;

            if (gi == 0) begin : g_first
                assign d = din;
            end else begin : g_next
                assign d = chain[gi-1];
            end

            // One flop of the metastability chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= 1'b0;
                end else begin
                    q_reg <= d;
                end
            end

            assign chain[gi] = q_reg;
        end
    endgenerate

    // Previous synchronised level; forced high on arm to mask a pre-existing level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg <= 1'b0;
        end else if (arm) begin
            prev_reg <= 1'b1;
        end else begin
            prev_reg <= chain[STAGES-1];
        end
    end

    assign rise = chain[STAGES-1] & ~prev_reg;

endmodule

// File: rtl/tdc_sequencer.sv
// Measurement controller for the TDC delay line. START opens a hit window
// (HIT_EN), a coarse counter runs until the synchronised COUNT_ON rises or
// the window expires, and the {coarse, fine} result is offered on a
// VALID/READY port until it is accepted.
module tdc_sequencer
    import tdc_pkg::*;
#(
    parameter int COARSE_W    = DEF_COARSE_W,
    parameter int FINE_W      = DEF_FINE_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       hit_en,
    input  logic                       count_on,
    input  logic [FINE_W-1:0]          z,
    output logic [COARSE_W+FINE_W-1:0] data,
    output logic                       valid,
    input  logic                       ready,
    output logic                       timeout_flag,
    output logic                       busy
);

    localparam int DATA_W = COARSE_W + FINE_W;

    localparam logic [COARSE_W-1:0] LAST_COUNT   = COARSE_W'(TIMEOUT - 1);
    localparam logic [COARSE_W-1:0] SYNC_OFFSET  = COARSE_W'(SYNC_STAGES);
    localparam logic [DATA_W-1:0]   TIMEOUT_CODE = '1;

    logic [1:0]          state_reg;
    logic [1:0]          state_next;
    logic [COARSE_W-1:0] counter_reg;
    logic [COARSE_W-1:0] counter_next;
    logic [DATA_W-1:0]   data_reg;
    logic [DATA_W-1:0]   data_next;
    logic                flag_reg;
    logic                flag_next;

    logic                handshake;
    logic                arm;
    logic                hit_rise;
    logic [COARSE_W-1:0] coarse_hit;
    logic [FINE_W-1:0]   z_aligned;

    wire  [SYNC_STAGES-1:0][FINE_W-1:0] z_chain;

    // A new window opens from IDLE, or straight from HOLD on the handshake cycle
    assign handshake = (state_reg == ST_HOLD) & ready;
    assign arm       = start & ((state_reg == ST_IDLE) | handshake);

    tdc_sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (count_on),
        .arm   (arm),
        .rise  (hit_rise)
    );

    // Z follows COUNT_ON through an equally deep pipeline so the fine code
    // presented with an edge is the one sampled together with that edge.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_zpipe
            logic [FINE_W-1:0] d;
            logic [FINE_W-1:0] q_reg;

            if (gi == 0) begin : g_first
                assign d = z;
            end else begin : g_next
                assign d = z_chain[gi-1];
            end

            // One stage of the fine-code alignment pipeline
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else begin
                    q_reg <= d;
                end
            end

            assign z_chain[gi] = q_reg;
        end
    endgenerate

    assign z_aligned = z_chain[SYNC_STAGES-1];

    // Undo the synchroniser delay; an edge that was in flight at arm time
    // can surface before SYNC_STAGES counts have elapsed, so clamp at zero.
    assign coarse_hit = (counter_reg >= SYNC_OFFSET) ? (counter_reg - SYNC_OFFSET) : '0;

    // Next-state, counter and result decisions
    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        data_next    = data_reg;
        flag_next    = flag_reg;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_ARMED;
                    counter_next = '0;
                end
            end

            ST_ARMED: begin
                if (hit_rise) begin
                    // A hit on the last window cycle still counts as a hit
                    state_next = ST_HOLD;
                    data_next  = {coarse_hit, z_aligned};
                    flag_next  = 1'b0;
                end else if (counter_reg == LAST_COUNT) begin
                    state_next = ST_HOLD;
                    data_next  = TIMEOUT_CODE;
                    flag_next  = 1'b1;
                end else begin
                    // Only counts while the window stays open, so it never wraps
                    counter_next = counter_reg + COARSE_W'(1);
                end
            end

            ST_HOLD: begin
                if (ready) begin
                    flag_next = 1'b0;
                    if (start) begin
                        state_next   = ST_ARMED;
                        counter_next = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, coarse counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            counter_reg <= '0;
            data_reg    <= '0;
            flag_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            data_reg    <= data_next;
            flag_reg    <= flag_next;
        end
    end

    assign hit_en       = (state_reg == ST_ARMED);
    assign valid        = (state_reg == ST_HOLD);
    assign busy         = (state_reg != ST_IDLE);
    assign data         = data_reg;
    assign timeout_flag = flag_reg;

endmodule

// File: tb/tb_tdc_sequencer.sv
// Self-checking bench for tdc_sequencer. Inputs change and outputs are
// sampled on the falling clock edge. Expected results come from a
// measurement-level model: a line first sampled high at counter value H is
// a hit with coarse H when H + SYNC_STAGES still lies inside the window,
// otherwise the window times out.
module tb_tdc_sequencer;

    localparam int COARSE_W    = 16;
    localparam int FINE_W      = 4;
    localparam int TIMEOUT     = 1000;
    localparam int SYNC_STAGES = 2;
    localparam int DW          = COARSE_W + FINE_W;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          start    = 1'b0;
    logic          count_on = 1'b0;
    logic          ready    = 1'b0;
    logic [FINE_W-1:0] z    = '0;
    logic          hit_en;
    logic [DW-1:0] data;
    logic          valid;
    logic          timeout_flag;
    logic          busy;

    int checks = 0;
    int errors = 0;

    tdc_sequencer #(
        .COARSE_W    (COARSE_W),
        .FINE_W      (FINE_W),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .hit_en       (hit_en),
        .count_on     (count_on),
        .z            (z),
        .data         (data),
        .valid        (valid),
        .ready        (ready),
        .timeout_flag (timeout_flag),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Reference: outcome of one measurement. hit_at < 0 means no hit.
    // Latency is counted in cycles from the first cycle after the arm edge.
    function automatic void model(input int hit_at, input logic [FINE_W-1:0] zval,
                                  output logic [DW-1:0] exp_data, output logic exp_flag,
                                  output int exp_lat);
        if (hit_at >= 0 && hit_at + SYNC_STAGES <= TIMEOUT - 1) begin
            exp_data = {COARSE_W'(hit_at), zval};
            exp_flag = 1'b0;
            exp_lat  = hit_at + SYNC_STAGES + 1;
        end else begin
            exp_data = '1;
            exp_flag = 1'b1;
            exp_lat  = TIMEOUT;
        end
    endfunction

    // Request a window; returns on the first falling edge after the arm edge
    task automatic arm_window();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Run the window until VALID (bounded). COUNT_ON rises at cycle hit_at
    // together with Z=zval; Z is random on every other cycle.
    task automatic wait_valid(input int hit_at, input logic [FINE_W-1:0] zval,
                              input int c0, output int lat);
        lat = -1;
        for (int c = c0; c <= TIMEOUT + 50; c++) begin
            if (valid === 1'b1) begin
                lat = c;
                break;
            end
            if (c == hit_at) begin
                count_on = 1'b1;
                z        = zval;
            end else begin
                z = FINE_W'($urandom);
            end
            @(negedge clk);
        end
    endtask

    // Accept the held result
    task automatic release_result();
        ready    = 1'b1;
        count_on = 1'b0;
        @(negedge clk);
        ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({hit_en, valid, busy, timeout_flag} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_por_flags got %b expected 0000", {hit_en, valid, busy, timeout_flag});
        end
        checks++;
        if (data !== '0) begin
            errors++;
            $display("FAIL reset_por_data got %h expected 0", data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        arm_window();
        repeat (10) @(negedge clk);
        checks++;
        if ({busy, hit_en, valid} !== 3'b110) begin
            errors++;
            $display("FAIL reset_armed got %b expected 110", {busy, hit_en, valid});
        end
        // Assert reset between clock edges: outputs must clear without a clock
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({hit_en, valid, busy, timeout_flag} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async_flags got %b expected 0000", {hit_en, valid, busy, timeout_flag});
        end
        checks++;
        if (data !== '0) begin
            errors++;
            $display("FAIL reset_async_data got %h expected 0", data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, valid, hit_en} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle got %b expected 000", {busy, valid, hit_en});
        end
        $display("reset: busy=%b valid=%b hit_en=%b data=%h", busy, valid, hit_en, data);
    endtask

    task automatic test_single_hit();
        logic [DW-1:0] ed;
        logic ef;
        int el, lat;
        model(50, 4'h9, ed, ef, el);
        arm_window();
        checks++;
        if ({busy, hit_en, valid} !== 3'b110) begin
            errors++;
            $display("FAIL single_armed got %b expected 110", {busy, hit_en, valid});
        end
        wait_valid(50, 4'h9, 0, lat);
        checks++;
        if (lat !== el) begin
            errors++;
            $display("FAIL single_latency got %0d expected %0d", lat, el);
        end
        checks++;
        if (data !== ed || timeout_flag !== ef) begin
            errors++;
            $display("FAIL single_result got %h/%b expected %h/%b", data, timeout_flag, ed, ef);
        end
        checks++;
        if (hit_en !== 1'b0) begin
            errors++;
            $display("FAIL single_hit_en got %b expected 0", hit_en);
        end
        $display("single_hit: data=%h flag=%b lat=%0d", data, timeout_flag, lat);
        release_result();
        checks++;
        if ({valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_release got %b expected 00", {valid, busy});
        end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] ed;
        logic ef;
        int el, lat;
        model(-1, 4'h0, ed, ef, el);
        arm_window();
        wait_valid(-1, 4'h0, 0, lat);
        checks++;
        if (lat !== el) begin
            errors++;
            $display("FAIL timeout_latency got %0d expected %0d", lat, el);
        end
        checks++;
        if (data !== ed || timeout_flag !== ef || hit_en !== 1'b0) begin
            errors++;
            $display("FAIL timeout_result got %h/%b/%b expected %h/%b/0", data, timeout_flag, hit_en, ed, ef);
        end
        $display("timeout: data=%h flag=%b lat=%0d", data, timeout_flag, lat);
        release_result();
        checks++;
        if ({valid, busy, timeout_flag} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_release got %b expected 000", {valid, busy, timeout_flag});
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] ed;
        logic ef;
        int el, lat, bad;
        logic [FINE_W-1:0] zv;
        zv = FINE_W'($urandom);
        model(20, zv, ed, ef, el);
        arm_window();
        wait_valid(20, zv, 0, lat);
        checks++;
        if (data !== ed || lat !== el) begin
            errors++;
            $display("FAIL bp_result got %h lat %0d expected %h lat %0d", data, lat, ed, el);
        end
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            count_on = ~count_on;
            z        = FINE_W'($urandom);
            @(negedge clk);
            checks++;
            if (valid !== 1'b1 || data !== ed || timeout_flag !== 1'b0) begin
                errors++;
                bad++;
                $display("FAIL bp_hold cycle %0d got %b/%h expected 1/%h", k, valid, data, ed);
            end
        end
        $display("backpressure: data=%h held 20 cycles, unstable=%0d", data, bad);
        release_result();
        checks++;
        if ({valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL bp_release got %b expected 00", {valid, busy});
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] ed;
        logic ef;
        int el, lat;
        logic [FINE_W-1:0] zv;
        zv = FINE_W'($urandom);
        model(30, zv, ed, ef, el);
        arm_window();
        wait_valid(30, zv, 0, lat);
        checks++;
        if (data !== ed) begin
            errors++;
            $display("FAIL b2b_first got %h expected %h", data, ed);
        end
        // Accept and re-arm in the same cycle
        ready    = 1'b1;
        start    = 1'b1;
        count_on = 1'b0;
        @(negedge clk);
        ready = 1'b0;
        start = 1'b0;
        checks++;
        if ({busy, hit_en, valid} !== 3'b110) begin
            errors++;
            $display("FAIL b2b_rearm got %b expected 110", {busy, hit_en, valid});
        end
        zv = FINE_W'($urandom);
        model(7, zv, ed, ef, el);
        wait_valid(7, zv, 0, lat);
        checks++;
        if (data !== ed || timeout_flag !== ef || lat !== el) begin
            errors++;
            $display("FAIL b2b_second got %h/%b lat %0d expected %h/%b lat %0d", data, timeout_flag, lat, ed, ef, el);
        end
        $display("back_to_back: data=%h flag=%b lat=%0d", data, timeout_flag, lat);
        release_result();
    endtask

    task automatic test_edge_cases();
        logic [DW-1:0] ed;
        logic ef;
        int el, lat;
        logic [FINE_W-1:0] zv;

        // Line already high when the window opens
        count_on = 1'b1;
        repeat (5) @(negedge clk);
        arm_window();
        repeat (20) @(negedge clk);
        checks++;
        if ({valid, hit_en} !== 2'b01) begin
            errors++;
            $display("FAIL edge_prehigh got %b expected 01", {valid, hit_en});
        end
        count_on = 1'b0;
        repeat (5) @(negedge clk);
        zv = FINE_W'($urandom);
        model(30, zv, ed, ef, el);
        wait_valid(30, zv, 25, lat);
        checks++;
        if (data !== ed || timeout_flag !== ef || lat !== el) begin
            errors++;
            $display("FAIL edge_rehit got %h/%b lat %0d expected %h/%b lat %0d", data, timeout_flag, lat, ed, ef, el);
        end
        $display("edge_prehigh: data=%h flag=%b lat=%0d", data, timeout_flag, lat);
        release_result();

        // Edge detected on the last window cycle, and one cycle too late
        for (int h = TIMEOUT - SYNC_STAGES - 1; h <= TIMEOUT - SYNC_STAGES; h++) begin
            zv = FINE_W'($urandom);
            model(h, zv, ed, ef, el);
            arm_window();
            wait_valid(h, zv, 0, lat);
            checks++;
            if (data !== ed || timeout_flag !== ef || lat !== el) begin
                errors++;
                $display("FAIL edge_window_end h=%0d got %h/%b lat %0d expected %h/%b lat %0d", h, data, timeout_flag, lat, ed, ef, el);
            end
            $display("edge_window_end: hit_at=%0d data=%h flag=%b lat=%0d", h, data, timeout_flag, lat);
            release_result();
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] ed;
        logic ef;
        int el, lat, h, n;
        logic [FINE_W-1:0] zv;
        for (int r = 0; r < 10; r++) begin
            h  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TIMEOUT + 5));
            zv = FINE_W'($urandom);
            model(h, zv, ed, ef, el);
            arm_window();
            wait_valid(h, zv, 0, lat);
            checks++;
            if (data !== ed || timeout_flag !== ef || lat !== el) begin
                errors++;
                $display("FAIL random_run %0d got %h/%b lat %0d expected %h/%b lat %0d", r, data, timeout_flag, lat, ed, ef, el);
            end
            n = int'($urandom_range(0, 3));
            for (int k = 0; k < n; k++) begin
                z        = FINE_W'($urandom);
                count_on = 1'($urandom);
                @(negedge clk);
                checks++;
                if (valid !== 1'b1 || data !== ed) begin
                    errors++;
                    $display("FAIL random_hold %0d got %b/%h expected 1/%h", r, valid, data, ed);
                end
            end
            $display("random %0d: hit_at=%0d data=%h flag=%b lat=%0d", r, h, data, timeout_flag, lat);
            release_result();
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL random_release %0d got %b expected 0", r, valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_edge_cases();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before the test sequence finished");
        $fatal(1, "watchdog");
    end

endmodule
